// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-outstanding memory port between the instruction-fetch
// requester and the load/store requester of the main pipeline.
//
// Data accesses win arbitration by default. A saturating starvation counter
// forces a fetch grant once STARVE_LIMIT data accesses have been accepted
// back-to-back while a fetch was waiting, so fetch always makes progress.
//
// A fetch in flight when FLUSH arrives is remembered as squashed; its
// response is consumed but never presented on INST_RVALID.
//
// Ports
//   CLK, RST         clock; synchronous active-high reset
//   FLUSH            pipeline flush, cancels the fetch in flight
//   INST_*           fetch requester: RDEN/RIADDR in, RVALID/ROADDR/RDATA out
//   MEM_WAIT         fetch request not accepted this cycle
//   DATA_*           load/store requester: RDEN/WREN/ADDR/WDATA/WSTRB in,
//                    RVALID/RDATA out
//   DATA_WAIT        data access not complete this cycle
//   M_*              memory port: REQ/WE/ADDR/WDATA/WSTRB out,
//                    READY/RVALID/RDATA in
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  // fetch side
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MEM_WAIT,
  // load/store side
  input  logic        DATA_RDEN,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_ADDR,
  input  logic [31:0] DATA_WDATA,
  input  logic [3:0]  DATA_WSTRB,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  output logic        DATA_WAIT,
  // memory port
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  input  logic        M_READY,
  input  logic        M_RVALID,
  input  logic [31:0] M_RDATA
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_I = 2'd1,   // fetch read outstanding
    S_WAIT_D = 2'd2    // load read outstanding
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_starve;
  logic            r_squash;
  logic [31:0]     r_raddr;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic w_resp_i, w_resp_d;
  logic w_arb;
  logic w_inst_cand, w_data_cand;
  logic w_starved;
  logic w_gnt_i, w_gnt_d;
  logic w_acc_i, w_acc_ld, w_acc_st;

  assign w_resp_i    = (r_state == S_WAIT_I) && M_RVALID;
  assign w_resp_d    = (r_state == S_WAIT_D) && M_RVALID;

  // A new request may issue from IDLE, or in the very cycle the outstanding
  // read returns, which keeps back-to-back single-cycle reads at full rate.
  // Nothing issues while reset is held.
  assign w_arb       = !RST && ((r_state == S_IDLE) || w_resp_i || w_resp_d);

  assign w_inst_cand = INST_RDEN && !FLUSH;
  assign w_data_cand = DATA_RDEN || DATA_WREN;
  assign w_starved   = (r_starve == LIMIT);

  assign w_gnt_i     = w_arb && w_inst_cand && (!w_data_cand || w_starved);
  assign w_gnt_d     = w_arb && w_data_cand && !w_gnt_i;

  assign w_acc_i     = w_gnt_i && M_READY;
  assign w_acc_ld    = w_gnt_d && M_READY && !DATA_WREN;
  assign w_acc_st    = w_gnt_d && M_READY &&  DATA_WREN;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // At an arbitration point the state is fully re-decided: a read acceptance
  // opens a response phase, anything else (store, stalled request, no
  // request) lands in IDLE. Outside arbitration points the state holds.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_arb) begin
      if (w_acc_i)       w_state_nxt = S_WAIT_I;
      else if (w_acc_ld) w_state_nxt = S_WAIT_D;
      else               w_state_nxt = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    M_REQ       = w_gnt_i || w_gnt_d;
    M_WE        = w_gnt_d && DATA_WREN;
    M_ADDR      = 32'h0;
    if (w_gnt_i)      M_ADDR = INST_RIADDR;
    else if (w_gnt_d) M_ADDR = DATA_ADDR;
    M_WDATA     = M_WE ? DATA_WDATA : 32'h0;
    M_WSTRB     = M_WE ? DATA_WSTRB : 4'h0;

    // A FLUSH coinciding with the response kills it just like an earlier one.
    INST_RVALID = !RST && w_resp_i && !r_squash && !FLUSH;
    INST_ROADDR = r_raddr;
    INST_RDATA  = M_RDATA;

    DATA_RVALID = !RST && w_resp_d;
    DATA_RDATA  = M_RDATA;

    // Fetch is released on acceptance; data is released on completion
    // (store acceptance or load data), so a load issue cycle still waits.
    MEM_WAIT    = INST_RDEN && !w_acc_i;
    DATA_WAIT   = w_data_cand && !(w_acc_st || DATA_RVALID);
  end

  // -------------------------------------------------------------------------
  // Starvation counter, squash flag, return address
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve <= '0;
      r_squash <= 1'b0;
      r_raddr  <= 32'h0;
    end else begin
      // Counts data wins over a waiting fetch; any gap in fetch demand or
      // a fetch acceptance restarts the count.
      if (!w_inst_cand || w_acc_i)
        r_starve <= '0;
      else if ((w_acc_ld || w_acc_st) && !w_starved)
        r_starve <= r_starve + 1'b1;

      // The squashed response still has to be drained from memory, so the
      // flag lives until that response shows up.
      if (r_state == S_WAIT_I) begin
        if (M_RVALID)   r_squash <= 1'b0;
        else if (FLUSH) r_squash <= 1'b1;
      end

      if (w_acc_i)
        r_raddr <= INST_RIADDR;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK, RST, FLUSH;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        INST_RVALID;
  logic [31:0] INST_ROADDR, INST_RDATA;
  logic        MEM_WAIT;
  logic        DATA_RDEN, DATA_WREN;
  logic [31:0] DATA_ADDR, DATA_WDATA;
  logic [3:0]  DATA_WSTRB;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WAIT;
  logic        M_REQ, M_WE;
  logic [31:0] M_ADDR, M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_READY, M_RVALID;
  logic [31:0] M_RDATA;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RVALID(INST_RVALID),
    .INST_ROADDR(INST_ROADDR), .INST_RDATA(INST_RDATA), .MEM_WAIT(MEM_WAIT),
    .DATA_RDEN(DATA_RDEN), .DATA_WREN(DATA_WREN), .DATA_ADDR(DATA_ADDR),
    .DATA_WDATA(DATA_WDATA), .DATA_WSTRB(DATA_WSTRB), .DATA_RVALID(DATA_RVALID),
    .DATA_RDATA(DATA_RDATA), .DATA_WAIT(DATA_WAIT),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_WSTRB(M_WSTRB), .M_READY(M_READY), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } macc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } irsp_t;

  macc_t       exp_macc[$];
  irsp_t       exp_irsp[$];
  logic [31:0] exp_drsp[$];

  int n_tests = 0;
  int n_fail  = 0;

  int          mem_lat = 1;
  int          mem_rem = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic push_rd(input logic [31:0] a);
    macc_t m;
    m.we = 1'b0; m.addr = a; m.wdata = 32'h0; m.wstrb = 4'h0;
    exp_macc.push_back(m);
  endtask

  task automatic push_f(input logic [31:0] a);
    irsp_t r;
    push_rd(a);
    r.addr = a; r.data = mem_f(a);
    exp_irsp.push_back(r);
  endtask

  task automatic push_ld(input logic [31:0] a);
    push_rd(a);
    exp_drsp.push_back(mem_f(a));
  endtask

  // Memory model: read accepted in cycle N answers in cycle N+mem_lat.
  initial begin
    M_RVALID = 1'b0;
    M_RDATA  = 32'h0;
    forever begin
      @(posedge CLK); #1;
      M_RVALID = 1'b0;
      if (mem_rem > 0) begin
        mem_rem--;
        if (mem_rem == 0) begin
          M_RVALID = 1'b1;
          M_RDATA  = mem_f(mem_addr);
        end
      end
      @(negedge CLK);
      if (M_REQ && M_READY && !M_WE) begin
        mem_rem  = mem_lat;
        mem_addr = M_ADDR;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  initial begin
    macc_t       em;
    irsp_t       ei;
    logic [31:0] ed;
    forever begin
      @(negedge CLK);
      if (M_REQ && M_READY) begin
        if (exp_macc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL macc_unexpected: got addr %h we %b, want no request", M_ADDR, M_WE);
        end else begin
          em = exp_macc.pop_front();
          chkb("macc_we", M_WE, em.we);
          chk("macc_addr", M_ADDR, em.addr);
          if (em.we) begin
            chk("macc_wdata", M_WDATA, em.wdata);
            chk("macc_wstrb", {28'h0, M_WSTRB}, {28'h0, em.wstrb});
          end
        end
      end
      if (INST_RVALID) begin
        if (exp_irsp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL irsp_unexpected: got roaddr %h, want no response", INST_ROADDR);
        end else begin
          ei = exp_irsp.pop_front();
          chk("irsp_addr", INST_ROADDR, ei.addr);
          chk("irsp_data", INST_RDATA, ei.data);
        end
      end
      if (DATA_RVALID) begin
        if (exp_drsp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL drsp_unexpected: got data %h, want no response", DATA_RDATA);
        end else begin
          ed = exp_drsp.pop_front();
          chk("drsp_data", DATA_RDATA, ed);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [9:0] s2_ig;
    logic [9:0] s2_dw;
    s2_ig = 10'b10_0001_0000;   // cycle i grants fetch
    s2_dw = 10'b00_0010_0001;   // expected DATA_WAIT per cycle

    RST = 1'b1; FLUSH = 1'b0;
    INST_RDEN = 1'b0; INST_RIADDR = 32'h0;
    DATA_RDEN = 1'b0; DATA_WREN = 1'b0; DATA_ADDR = 32'h0;
    DATA_WDATA = 32'h0; DATA_WSTRB = 4'h0;
    M_READY = 1'b1;

    // reset state
    step();
    mid();
    chkb("rst_mreq", M_REQ, 1'b0);
    chkb("rst_irv", INST_RVALID, 1'b0);
    chkb("rst_drv", DATA_RVALID, 1'b0);
    chkb("rst_mwait", MEM_WAIT, 1'b0);
    chkb("rst_dwait", DATA_WAIT, 1'b0);
    chk("rst_roaddr", INST_ROADDR, 32'h0);
    step();
    RST = 1'b0;
    mid(); step();

    // 1: back-to-back fetches, one-cycle memory
    mem_lat = 1;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0000; push_f(32'h2000_0000);
    mid(); chkb("s1_mwait0", MEM_WAIT, 1'b0); chkb("s1_irv0", INST_RVALID, 1'b0);
    step();
    INST_RIADDR = 32'h2000_0004; push_f(32'h2000_0004);
    mid(); chkb("s1_mwait1", MEM_WAIT, 1'b0); chkb("s1_irv1", INST_RVALID, 1'b1);
    step();
    INST_RDEN = 1'b0;
    mid(); chkb("s1_mwait2", MEM_WAIT, 1'b0); chkb("s1_irv2", INST_RVALID, 1'b1);
    step();

    // 2: fetch and loads both requesting: 4 data grants, then fetch
    INST_RDEN = 1'b1; INST_RIADDR = 32'h2000_0100;
    DATA_RDEN = 1'b1; DATA_ADDR = 32'h1000_0000;
    for (int i = 0; i < 10; i++) begin
      if (s2_ig[i]) push_f(INST_RIADDR);
      else          push_ld(DATA_ADDR);
      mid();
      chkb($sformatf("s2_mwait[%0d]", i), MEM_WAIT, !s2_ig[i]);
      chkb($sformatf("s2_dwait[%0d]", i), DATA_WAIT, s2_dw[i]);
      step();
      if (s2_ig[i]) INST_RIADDR = INST_RIADDR + 32'd4;
    end
    INST_RDEN = 1'b0; DATA_RDEN = 1'b0;
    mid(); chkb("s2_irv_last", INST_RVALID, 1'b1); chkb("s2_mreq_end", M_REQ, 1'b0);
    step();
    mid(); step();

    // 3a: FLUSH the cycle after fetch acceptance, latency 3
    mem_lat = 3;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h3000_0000; push_rd(32'h3000_0000);
    mid(); chkb("s3_mwait0", MEM_WAIT, 1'b0);
    step();
    INST_RIADDR = 32'h4000_0000; FLUSH = 1'b1;
    mid(); chkb("s3_mwait1", MEM_WAIT, 1'b1); chkb("s3_mreq1", M_REQ, 1'b0);
    step();
    FLUSH = 1'b0;
    mid(); chkb("s3_mwait2", MEM_WAIT, 1'b1); chkb("s3_mreq2", M_REQ, 1'b0);
    step();
    push_f(32'h4000_0000);
    mid(); chkb("s3_irv_squash", INST_RVALID, 1'b0); chkb("s3_mwait3", MEM_WAIT, 1'b0);
    chkb("s3_mreq3", M_REQ, 1'b1);
    step();
    INST_RDEN = 1'b0;
    mid(); step();
    mid(); step();
    mid(); chkb("s3_irv_new", INST_RVALID, 1'b1);
    step();

    // 3b: FLUSH coinciding with the response
    mem_lat = 1;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h5000_0000; push_rd(32'h5000_0000);
    mid(); step();
    FLUSH = 1'b1; INST_RIADDR = 32'h5000_0010;
    mid(); chkb("s3b_irv_flush", INST_RVALID, 1'b0); chkb("s3b_mreq", M_REQ, 1'b0);
    step();
    FLUSH = 1'b0; push_f(32'h5000_0010);
    mid(); chkb("s3b_mwait", MEM_WAIT, 1'b0);
    step();
    INST_RDEN = 1'b0;
    mid(); chkb("s3b_irv", INST_RVALID, 1'b1);
    step();

    // 4: store stalled by M_READY for two cycles
    M_READY = 1'b0; DATA_WREN = 1'b1; DATA_ADDR = 32'h1000_0040;
    DATA_WDATA = 32'hDEAD_BEEF; DATA_WSTRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        macc_t m;
        M_READY = 1'b1;
        m.we = 1'b1; m.addr = 32'h1000_0040; m.wdata = 32'hDEAD_BEEF; m.wstrb = 4'hF;
        exp_macc.push_back(m);
      end
      mid();
      chkb($sformatf("s4_mreq[%0d]", i), M_REQ, 1'b1);
      chkb($sformatf("s4_mwe[%0d]", i), M_WE, 1'b1);
      chk($sformatf("s4_wstrb[%0d]", i), {28'h0, M_WSTRB}, 32'hF);
      chkb($sformatf("s4_dwait[%0d]", i), DATA_WAIT, (i != 2));
      step();
    end
    DATA_WREN = 1'b0;
    mid(); chkb("s4_mreq_end", M_REQ, 1'b0); chkb("s4_dwait_end", DATA_WAIT, 1'b0);
    step();

    // 5: reset while a load is outstanding; late response ignored
    mem_lat = 3;
    DATA_RDEN = 1'b1; DATA_ADDR = 32'h1000_0080; push_rd(32'h1000_0080);
    mid(); chkb("s5_dwait", DATA_WAIT, 1'b1);
    step();
    RST = 1'b1; DATA_RDEN = 1'b0;
    mid();
    chkb("s5_rst_mreq", M_REQ, 1'b0);
    chkb("s5_rst_drv", DATA_RVALID, 1'b0);
    chkb("s5_rst_irv", INST_RVALID, 1'b0);
    chkb("s5_rst_mwait", MEM_WAIT, 1'b0);
    chkb("s5_rst_dwait", DATA_WAIT, 1'b0);
    step();
    RST = 1'b0;
    mid(); step();
    mid(); chkb("s5_late_drv", DATA_RVALID, 1'b0); chkb("s5_late_mreq", M_REQ, 1'b0);
    step();

    // 6: load response and pending fetch in the same cycle
    mem_lat = 2;
    DATA_RDEN = 1'b1; DATA_ADDR = 32'h1000_00C0; push_ld(32'h1000_00C0);
    mid(); step();
    INST_RDEN = 1'b1; INST_RIADDR = 32'h6000_0000;
    mid(); chkb("s6_mreq1", M_REQ, 1'b0); chkb("s6_mwait1", MEM_WAIT, 1'b1);
    chkb("s6_dwait1", DATA_WAIT, 1'b1);
    step();
    DATA_RDEN = 1'b0; push_f(32'h6000_0000);
    mid(); chkb("s6_drv", DATA_RVALID, 1'b1); chkb("s6_mreq2", M_REQ, 1'b1);
    chkb("s6_mwe2", M_WE, 1'b0); chkb("s6_mwait2", MEM_WAIT, 1'b0);
    step();
    INST_RDEN = 1'b0;
    mid(); chkb("s6_irv3", INST_RVALID, 1'b0);
    step();
    mid(); chkb("s6_irv4", INST_RVALID, 1'b1);
    step();
    mid(); step();

    chk("end_macc_q", exp_macc.size(), 32'd0);
    chk("end_irsp_q", exp_irsp.size(), 32'd0);
    chk("end_drsp_q", exp_drsp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-outstanding memory port between the instruction-fetch requester and the load/store requester of the main pipeline. Data accesses have priority, with a starvation limit so fetch always progresses. The block generates the pipeline stall signals MEM_WAIT (fetch side) and DATA_WAIT (load/store side). It discards instruction responses squashed by FLUSH. It sits between the pipeline and the MMU.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  pipeline flush; cancels the fetch in flight
- INST_RDEN  in  1  fetch read request
- INST_RIADDR  in  32  fetch address
- INST_RVALID  out  1  fetch response valid, one-cycle pulse
- INST_ROADDR  out  32  address of the returned instruction
- INST_RDATA  out  32  returned instruction
- MEM_WAIT  out  1  fetch request not accepted this cycle
- DATA_RDEN  in  1  load request
- DATA_WREN  in  1  store request; RDEN and WREN are never both high
- DATA_ADDR  in  32  load/store address
- DATA_WDATA  in  32  store data
- DATA_WSTRB  in  4  store byte enables
- DATA_RVALID  out  1  load data valid pulse
- DATA_RDATA  out  32  load data
- DATA_WAIT  out  1  data access not complete this cycle
- M_REQ  out  1  memory request
- M_WE  out  1  request is a write
- M_ADDR  out  32  request address
- M_WDATA  out  32  write data
- M_WSTRB  out  4  write strobes
- M_READY  in  1  request accepted when M_REQ and M_READY are both high
- M_RVALID  in  1  read response; at least one cycle after acceptance
- M_RDATA  in  32  read data

## Operation
- States:
  - IDLE
  - WAIT_I: fetch read outstanding
  - WAIT_D: load outstanding
- At most one read is outstanding at any time.
- The arbitration point is IDLE, or WAIT_I/WAIT_D in the cycle M_RVALID arrives. Responses and new issues may coincide.
- Candidates at the arbitration point:
  - inst = INST_RDEN & !FLUSH
  - data = DATA_RDEN | DATA_WREN
- Grant rules:
  - If both candidates request and the starvation counter equals STARVE_LIMIT, inst is granted.
  - Otherwise, if both request, data is granted.
  - A lone requester is granted.
- The grant drives the M_* signals combinationally from the requester inputs. Requesters hold their inputs stable while their WAIT signal is high.
- Transitions on acceptance:
  - Fetch accepted: latch the address into the return-address register and go to WAIT_I.
  - Load accepted: go to WAIT_D.
  - Store accepted: stay at the arbitration point (no response phase).
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments when data is accepted while inst is a candidate.
  - Clears when inst is accepted, or in any cycle inst is not a candidate.
- A response with no grant accepted, or with M_READY low, returns the state to IDLE.
- WAIT_I:
  - On M_RVALID, INST_RVALID = !squash & !FLUSH, INST_RDATA = M_RDATA, INST_ROADDR = latched address.
  - FLUSH while in WAIT_I sets squash. Squash clears when the response arrives.
- WAIT_D: DATA_RVALID = M_RVALID and DATA_RDATA = M_RDATA.
- MEM_WAIT = INST_RDEN & !(fetch accepted this cycle).
- DATA_WAIT = data candidate & !(store accepted this cycle | DATA_RVALID this cycle). The load issue cycle keeps DATA_WAIT high.
- M_RVALID arriving in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; counter 0; squash 0; return-address register 0.
  - M_REQ 0; all RVALID outputs 0.
  - MEM_WAIT and DATA_WAIT follow their combinational equations, so both are 0 while requests are low.
- Reset mid-transaction drops the outstanding read. Any later M_RVALID is ignored.
- Fetch with M_READY=1 and one-cycle memory:
  - Request accepted in cycle N; INST_RVALID in N+1.
  - The next fetch may be accepted in N+1, giving one fetch per cycle.
- Store: accepted and complete in the same cycle; DATA_WAIT low that cycle.
- Load: DATA_WAIT high from the request cycle until the DATA_RVALID cycle inclusive-exclusive, i.e. low in the response cycle.
- FLUSH in the same cycle as M_RVALID in WAIT_I: INST_RVALID stays 0.

## Test plan
- Fetch only, M_READY=1, one-cycle latency, addresses 0x2000_0000 and 0x2000_0004 back-to-back -> INST_RVALID in cycles N+1 and N+2 with matching ROADDR; MEM_WAIT always 0.
- Fetch and load both requesting continuously, STARVE_LIMIT=4 -> four data grants, then one fetch grant, then the pattern repeats; counter saturates and never exceeds 4.
- FLUSH in the cycle after fetch acceptance, memory latency 3 -> no INST_RVALID for that fetch; the next fetch issues in the response cycle.
- Store with M_READY held low for 2 cycles, then high -> M_REQ=1, M_WE=1, WSTRB=0xF for 3 cycles; DATA_WAIT 1,1,0.
- Load outstanding, RST asserted, then M_RVALID arrives -> all outputs at reset values; DATA_RVALID stays 0.
- Load response and pending fetch in the same cycle -> DATA_RVALID=1 and fetch M_REQ=1 in that cycle; state moves to WAIT_I.
